// File: rtl/von_neumann_extractor_pkg.sv
// Shared definitions for the von Neumann extractor and its health test.
// Holds the pairing FSM encodings and the default sizing constants so the
// extractor, its sub-module and neighbouring benches agree on them.
package von_neumann_extractor_pkg;

    // Pairing FSM: waiting for the first member of a pair, or holding it.
    typedef enum logic {
        VNE_IDLE = 1'b0,
        VNE_HALF = 1'b1
    } vne_state_e;

    // Width of the discard and repetition counters.
    localparam int unsigned VNE_CNT_W_DEFAULT = 8;

    // Consecutive identical raw samples that declare the source stuck.
    localparam int unsigned VNE_RCT_CUTOFF_DEFAULT = 32;

    // Saturating increment on a counter of up to 32 bits; max is the ceiling.
    function automatic logic [31:0] vne_sat_inc(input logic [31:0] value,
                                                input logic [31:0] max);
        if (value >= max) begin
            return max;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/repetition_count_test.sv
// Repetition-count health test for a raw entropy stream.
// Counts consecutive identical accepted samples and raises a sticky alarm when
// the run length reaches RCT_CUTOFF. Only instantiated when VNE_HEALTH_EN is
// defined in the extractor build.
module repetition_count_test
    import von_neumann_extractor_pkg::*;
#(
    parameter int unsigned CNT_W      = VNE_CNT_W_DEFAULT,
    parameter int unsigned RCT_CUTOFF = VNE_RCT_CUTOFF_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic sample_valid,
    output logic alarm
);

    localparam logic [CNT_W-1:0] CUTOFF  = CNT_W'(RCT_CUTOFF);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_next;
    logic             prev_sample;

    // Run length after this cycle's sample; a zero count means no sample seen yet.
    always_comb begin
        rep_cnt_next = rep_cnt;
        if (sample_valid) begin
            if ((rep_cnt != '0) && (sample == prev_sample)) begin
                rep_cnt_next = CNT_W'(vne_sat_inc(32'(rep_cnt), 32'(CNT_MAX)));
            end else begin
                rep_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Track the run and latch the alarm on the same edge the cutoff is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt     <= '0;
            prev_sample <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            rep_cnt <= rep_cnt_next;
            if (sample_valid) begin
                prev_sample <= sample;
                if (rep_cnt_next >= CUTOFF) begin
                    alarm <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/von_neumann_extractor.sv
// Von Neumann debiasing stage feeding vector_buffer.
// Pairs accepted raw samples: 01 emits 0, 10 emits 1, 00/11 are discarded and
// counted. Output is a registered bit plus a one-cycle bit_valid pulse.
// Optional feature macro: VNE_HEALTH_EN adds a repetition-count health test
// whose sticky stuck_alarm suppresses bit_valid; without it stuck_alarm is 0.
// The spec's "bit" output is exposed as ext_bit since bit is a reserved word.
module von_neumann_extractor
    import von_neumann_extractor_pkg::*;
#(
    parameter int unsigned CNT_W      = VNE_CNT_W_DEFAULT,
    parameter int unsigned RCT_CUTOFF = VNE_RCT_CUTOFF_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             raw_bit,
    input  logic             raw_valid,
    output logic             ext_bit,
    output logic             bit_valid,
    output logic [CNT_W-1:0] discard_cnt,
    output logic             stuck_alarm
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    vne_state_e state;
    logic       first_bit;
    logic       pulse;
    logic       accept;

    assign accept = raw_valid & enable;

    // Pairing FSM with registered bit, pulse and discard counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= VNE_IDLE;
            first_bit   <= 1'b0;
            ext_bit     <= 1'b0;
            pulse       <= 1'b0;
            discard_cnt <= '0;
        end else begin
            pulse <= 1'b0;
            if (!enable) begin
                // Drop any held half-pair without counting it.
                state <= VNE_IDLE;
            end else if (accept) begin
                case (state)
                    VNE_IDLE: begin
                        first_bit <= raw_bit;
                        state     <= VNE_HALF;
                    end
                    VNE_HALF: begin
                        state <= VNE_IDLE;
                        if (raw_bit != first_bit) begin
                            ext_bit <= first_bit;
                            pulse   <= 1'b1;
                        end else begin
                            discard_cnt <= CNT_W'(vne_sat_inc(32'(discard_cnt),
                                                              32'(CNT_MAX)));
                        end
                    end
                    default: begin
                        state <= VNE_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef VNE_HEALTH_EN
    repetition_count_test #(
        .CNT_W      (CNT_W),
        .RCT_CUTOFF (RCT_CUTOFF)
    ) u_rct (
        .clk          (clk),
        .reset        (reset),
        .sample       (raw_bit),
        .sample_valid (accept),
        .alarm        (stuck_alarm)
    );

    // A stuck source must not leak bits downstream; the FSM keeps running.
    assign bit_valid = pulse & ~stuck_alarm;
`else
    assign stuck_alarm = 1'b0;
    assign bit_valid   = pulse;
`endif

endmodule

// File: tb/tb_von_neumann_extractor.sv
// Directed bench for von_neumann_extractor with an expected-bit scoreboard.
module tb_von_neumann_extractor;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       raw_bit;
    logic       raw_valid;
    logic       ext_bit;
    logic       bit_valid;
    logic [7:0] discard_cnt;
    logic       stuck_alarm;
    logic       ext_bit2;
    logic       bit_valid2;
    logic [1:0] discard_cnt2;
    logic       stuck_alarm2;

    int         checks = 0;
    int         errors = 0;
    logic       exp_q[$];
    logic [7:0] vec = 8'h00;
    logic       health;

    von_neumann_extractor #(
        .CNT_W      (8),
        .RCT_CUTOFF (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .ext_bit     (ext_bit),
        .bit_valid   (bit_valid),
        .discard_cnt (discard_cnt),
        .stuck_alarm (stuck_alarm)
    );

    von_neumann_extractor #(
        .CNT_W      (2),
        .RCT_CUTOFF (3)
    ) dut_narrow (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .raw_bit     (raw_bit),
        .raw_valid   (raw_valid),
        .ext_bit     (ext_bit2),
        .bit_valid   (bit_valid2),
        .discard_cnt (discard_cnt2),
        .stuck_alarm (stuck_alarm2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One raw sample per call; consecutive calls give back-to-back raw_valid.
    task automatic send(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every pulse must match the oldest expected bit.
    always @(negedge clk) begin
        if (reset === 1'b0 && bit_valid === 1'b1) begin
            check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("ext_bit", 32'(ext_bit), 32'(exp_q.pop_front()));
            end
            vec = {vec[6:0], ext_bit};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef VNE_HEALTH_EN
        health = 1'b1;
`else
        health = 1'b0;
`endif
        reset     = 1'b1;
        enable    = 1'b0;
        raw_bit   = 1'b0;
        raw_valid = 1'b0;
        idle(2);
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_ext_bit", 32'(ext_bit), 32'd0);
        check("rst_discard", 32'(discard_cnt), 32'd0);
        check("rst_alarm", 32'(stuck_alarm), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        idle(1);

        // Pairs 10, 01, 10 back-to-back.
        exp_q.push_back(1'b1);
        send(1'b1);
        send(1'b0);
        check("t1_latency", 32'(bit_valid), 32'd1);
        exp_q.push_back(1'b0);
        send(1'b0);
        send(1'b1);
        exp_q.push_back(1'b1);
        send(1'b1);
        send(1'b0);
        idle(3);
        check("t1_discard", 32'(discard_cnt), 32'd0);

        // Equal pairs 00, 11, 00, 11, then a fifth 00.
        send(1'b0); send(1'b0);
        send(1'b1); send(1'b1);
        send(1'b0); send(1'b0);
        send(1'b1); send(1'b1);
        idle(2);
        check("t2_discard4", 32'(discard_cnt), 32'd4);
        check("t2_narrow_sat4", 32'(discard_cnt2), 32'd3);
        send(1'b0); send(1'b0);
        idle(2);
        check("t2_discard5", 32'(discard_cnt), 32'd5);
        check("t2_narrow_sat5", 32'(discard_cnt2), 32'd3);

        // Half-pair dropped by enable low; a sample offered while disabled is ignored.
        send(1'b1);
        enable    = 1'b0;
        raw_bit   = 1'b0;
        raw_valid = 1'b1;
        idle(1);
        raw_valid = 1'b0;
        enable    = 1'b1;
        check("t3_no_pulse", 32'(bit_valid), 32'd0);
        exp_q.push_back(1'b0);
        send(1'b0);
        send(1'b1);
        idle(3);
        check("t3_discard_hold", 32'(discard_cnt), 32'd5);

        // Reset between pair members.
        send(1'b1);
        reset = 1'b1;
        #1;
        check("t4_rst_discard", 32'(discard_cnt), 32'd0);
        check("t4_rst_valid", 32'(bit_valid), 32'd0);
        check("t4_rst_bit", 32'(ext_bit), 32'd0);
        check("t4_rst_narrow", 32'(discard_cnt2), 32'd0);
        idle(1);
        reset = 1'b0;
        exp_q.push_back(1'b0);
        send(1'b0);
        send(1'b1);
        idle(3);

        // Eight 10 pairs assemble a byte of ones for the downstream buffer.
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(1'b1);
            send(1'b1);
            send(1'b0);
        end
        idle(3);
        check("t6_vector", 32'(vec), 32'h0000_00FF);
        check("t6_discard", 32'(discard_cnt), 32'd0);

        // Stuck source: 32 consecutive ones.
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 31; i++) begin
            send(1'b1);
        end
        check("t5_alarm_31", 32'(stuck_alarm), 32'd0);
        send(1'b1);
        check("t5_alarm_32", 32'(stuck_alarm), 32'(health));
        check("t5_discard", 32'(discard_cnt), 32'd16);
        if (!health) begin
            exp_q.push_back(1'b0);
        end
        send(1'b0);
        send(1'b1);
        idle(4);
        check("t5_alarm_sticky", 32'(stuck_alarm), 32'(health));
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
